// File: rtl/uart_tx_frame_sequencer.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_sequencer
//
// UART transmit frame engine. It accepts one payload word through a
// valid/ready handshake and serialises it as a complete frame:
//   start bit, N data bits (LSB first), optional parity bit, 1 or 2 stop bits.
// The frame advances one bit per baud_tick. The serial line is driven from a
// register, so it changes in the cycle after the tick edge.
//
// The data length, parity mode and stop-bit count are sampled when a frame is
// accepted. The frame in flight uses only those sampled values.
//
// Parameters
//   MAX_DATA_BITS : largest data length supported (legal range 5..9)
//   SEL_W         : width of bit_index (must hold 1+MAX_DATA_BITS+1+2-1)
//   IDLE_LEVEL    : line level when idle and during stop bits; the start bit
//                   uses the inverse level
//
// Ports
//   clk, rst       : clock; synchronous active-high reset
//   baud_tick      : one-cycle pulse at the end of each bit period
//   cfg_data_bits  : data bits per frame, clamped to 5..MAX_DATA_BITS
//   cfg_parity     : 00 none, 01 even, 10 odd, 11 mark (constant 1)
//   cfg_stop2      : 0 = one stop bit, 1 = two stop bits
//   tx_valid       : tx_data holds a word to send
//   tx_data        : payload; bits above the configured length are ignored
//   tx_ready       : high only when idle; a frame is accepted on
//                    tx_valid && tx_ready
//   tx_out         : serial line
//   bit_index      : index of the bit on the line (start = 0, data = 1..N,
//                    parity = N+1 when enabled, then the stop bits; 0 when idle)
//   busy           : a frame is in progress
//   frame_done     : one-cycle pulse as the final stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_frame_sequencer #(
    parameter int   MAX_DATA_BITS = 9,
    parameter int   SEL_W         = 4,
    parameter logic IDLE_LEVEL    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_tick,
    input  logic [3:0]               cfg_data_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    input  logic                     tx_valid,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    output logic                     tx_ready,
    output logic                     tx_out,
    output logic [SEL_W-1:0]         bit_index,
    output logic                     busy,
    output logic                     frame_done
);

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // -------------------------------------------------------------------------
    // Clamp a requested data length into the supported range.
    // -------------------------------------------------------------------------
    function automatic logic [3:0] clamp_len(input logic [3:0] req);
        logic [3:0] len;
        if (req < 4'd5)
            len = 4'd5;
        else if (int'(req) > MAX_DATA_BITS)
            len = 4'(MAX_DATA_BITS);
        else
            len = req;
        return len;
    endfunction

    // -------------------------------------------------------------------------
    // Parity over the first len data bits only. Even parity is the XOR of the
    // transmitted bits. Odd parity is its inverse. Mark parity is a constant 1.
    // In mode "none" the result is never transmitted.
    // -------------------------------------------------------------------------
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic [3:0]               len,
                                         input logic [1:0]               mode);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < int'(len))
                acc = acc ^ data[i];
        end
        if (mode == PAR_MARK)
            return 1'b1;
        else if (mode == PAR_ODD)
            return ~acc;
        else
            return acc;
    endfunction

    // Control state
    state_t             r_state;
    logic               r_tx_out;
    logic               r_tx_ready;
    logic               r_busy;
    logic               r_frame_done;
    logic [SEL_W-1:0]   r_bit_index;
    logic [3:0]         r_data_cnt;
    logic               r_stop_cnt;

    // Frame data and configuration sampled at accept
    logic [MAX_DATA_BITS-1:0] r_shift;
    logic [3:0]               r_nbits;
    logic [1:0]               r_parity_mode;
    logic                     r_stop2;
    logic                     r_par_bit;

    logic               w_accept;
    logic [3:0]         w_len;
    logic               w_par_bit;

    assign w_accept  = tx_valid & r_tx_ready;
    assign w_len     = clamp_len(cfg_data_bits);
    assign w_par_bit = calc_parity(tx_data, w_len, cfg_parity);

    // -------------------------------------------------------------------------
    // Frame FSM. The registers that hold frame data and the sampled
    // configuration have no reset. They are written only at accept, so their
    // contents are meaningless outside a frame.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tx_out     <= IDLE_LEVEL;
            r_tx_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_bit_index  <= '0;
            r_data_cnt   <= '0;
            r_stop_cnt   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            case (r_state)
                // A tick in the accept cycle is ignored. The start bit lasts
                // until the next tick, so it may be shorter than one bit period.
                S_IDLE: begin
                    if (w_accept) begin
                        r_state       <= S_START;
                        r_tx_out      <= ~IDLE_LEVEL;
                        r_tx_ready    <= 1'b0;
                        r_busy        <= 1'b1;
                        r_bit_index   <= '0;
                        r_stop_cnt    <= 1'b0;
                        r_shift       <= tx_data;
                        r_nbits       <= w_len;
                        r_parity_mode <= cfg_parity;
                        r_stop2       <= cfg_stop2;
                        r_par_bit     <= w_par_bit;
                    end
                end

                S_START: begin
                    if (baud_tick) begin
                        r_state     <= S_DATA;
                        r_tx_out    <= r_shift[0];
                        r_shift     <= r_shift >> 1;
                        r_data_cnt  <= 4'd1;
                        r_bit_index <= r_bit_index + SEL_W'(1);
                    end
                end

                // r_data_cnt counts the data bits already placed on the line.
                S_DATA: begin
                    if (baud_tick) begin
                        r_bit_index <= r_bit_index + SEL_W'(1);
                        if (r_data_cnt == r_nbits) begin
                            r_stop_cnt <= 1'b0;
                            if (r_parity_mode != PAR_NONE) begin
                                r_state  <= S_PARITY;
                                r_tx_out <= r_par_bit;
                            end else begin
                                r_state  <= S_STOP;
                                r_tx_out <= IDLE_LEVEL;
                            end
                        end else begin
                            r_tx_out   <= r_shift[0];
                            r_shift    <= r_shift >> 1;
                            r_data_cnt <= r_data_cnt + 4'd1;
                        end
                    end
                end

                S_PARITY: begin
                    if (baud_tick) begin
                        r_state     <= S_STOP;
                        r_tx_out    <= IDLE_LEVEL;
                        r_stop_cnt  <= 1'b0;
                        r_bit_index <= r_bit_index + SEL_W'(1);
                    end
                end

                // With two stop bits the first tick only advances bit_index.
                // The line already sits at the stop level.
                S_STOP: begin
                    if (baud_tick) begin
                        if (r_stop2 && !r_stop_cnt) begin
                            r_stop_cnt  <= 1'b1;
                            r_bit_index <= r_bit_index + SEL_W'(1);
                        end else begin
                            r_state      <= S_IDLE;
                            r_tx_out     <= IDLE_LEVEL;
                            r_tx_ready   <= 1'b1;
                            r_busy       <= 1'b0;
                            r_bit_index  <= '0;
                            r_frame_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_tx_out   <= IDLE_LEVEL;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_bit_index <= '0;
                end
            endcase
        end
    end

    assign tx_ready   = r_tx_ready;
    assign tx_out     = r_tx_out;
    assign bit_index  = r_bit_index;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for uart_tx_frame_sequencer.
//
// A reference model runs on each rising edge. It decides acceptance from the
// stimulus and its own frame timer. On each accept it pushes the expected
// {bit_index, line level} sequence of the frame onto a queue. A monitor runs
// on each falling edge. It compares the handshake and status outputs with the
// model every cycle. It pops and checks one queue entry each time a new bit
// appears on the line.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame_sequencer;

    localparam int MAXB = 9;
    localparam int SELW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            baud_tick = 1'b0;
    logic [3:0]      cfg_data_bits = 4'd8;
    logic [1:0]      cfg_parity = 2'b00;
    logic            cfg_stop2 = 1'b0;
    logic            tx_valid = 1'b0;
    logic [MAXB-1:0] tx_data = '0;
    logic            tx_ready;
    logic            tx_out;
    logic [SELW-1:0] bit_index;
    logic            busy;
    logic            frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_frame_sequencer #(
        .MAX_DATA_BITS(MAXB),
        .SEL_W        (SELW),
        .IDLE_LEVEL   (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .cfg_data_bits(cfg_data_bits),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .tx_out       (tx_out),
        .bit_index    (bit_index),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Baud tick: one pulse every 16 clocks
    int tick_cnt = 0;
    initial forever begin
        @(negedge clk);
        tick_cnt  = (tick_cnt == 15) ? 0 : tick_cnt + 1;
        baud_tick = (tick_cnt == 15);
    end

    // ---------------- reference model ----------------
    int bitq[$];        // entries are idx*2 + level
    int m_rem   = 0;    // baud ticks left in the current frame, 0 = idle
    bit m_done  = 1'b0;
    bit chk_en  = 1'b0;
    int acc_cnt = 0;

    function automatic int model_push(input logic [MAXB-1:0] d, input logic [3:0] nb,
                                      input logic [1:0] par, input logic s2);
        int n;
        int idx;
        logic p;
        n   = (nb < 4'd5) ? 5 : ((int'(nb) > MAXB) ? MAXB : int'(nb));
        idx = 0;
        bitq.push_back(idx * 2 + 0);
        idx++;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            bitq.push_back(idx * 2 + int'(d[i]));
            p = p ^ d[i];
            idx++;
        end
        if (par != 2'b00) begin
            if (par == 2'b10) p = ~p;
            if (par == 2'b11) p = 1'b1;
            bitq.push_back(idx * 2 + int'(p));
            idx++;
        end
        bitq.push_back(idx * 2 + 1);
        idx++;
        if (s2) begin
            bitq.push_back(idx * 2 + 1);
            idx++;
        end
        return idx;   // frame length in ticks
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_rem  = 0;
            m_done = 1'b0;
            bitq.delete();
            chk_en = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_rem == 0) begin
                if (tx_valid) begin
                    m_rem = model_push(tx_data, cfg_data_bits, cfg_parity, cfg_stop2);
                    acc_cnt++;
                end
            end else if (baud_tick) begin
                m_rem--;
                if (m_rem == 0) m_done = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic            p_busy = 1'b0;
    logic [SELW-1:0] p_idx  = '0;
    logic            p_out  = 1'b1;
    int max_idx  = 0;
    int done_cnt = 0;
    int gap      = 0;
    int last_gap = -1;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_chk++;
            if (busy !== (m_rem != 0)) begin
                n_fail++;
                $display("FAIL busy: got %b expected %b at %0t", busy, (m_rem != 0), $time);
            end
            n_chk++;
            if (tx_ready !== (m_rem == 0)) begin
                n_fail++;
                $display("FAIL tx_ready: got %b expected %b at %0t", tx_ready, (m_rem == 0), $time);
            end
            n_chk++;
            if (frame_done !== m_done) begin
                n_fail++;
                $display("FAIL frame_done: got %b expected %b at %0t", frame_done, m_done, $time);
            end
            if (m_rem == 0) begin
                n_chk++;
                if (tx_out !== 1'b1 || bit_index !== '0) begin
                    n_fail++;
                    $display("FAIL idle_line: got out=%b idx=%0d expected out=1 idx=0 at %0t",
                             tx_out, bit_index, $time);
                end
            end
            if (busy === 1'b1 && (p_busy !== 1'b1 || bit_index !== p_idx)) begin
                n_chk++;
                if (bitq.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_bit: got idx=%0d out=%b expected no bit at %0t",
                             bit_index, tx_out, $time);
                end else begin
                    int e;
                    e = bitq.pop_front();
                    if (int'(bit_index) !== e / 2 || tx_out !== e[0]) begin
                        n_fail++;
                        $display("FAIL line_bit: got idx=%0d out=%b expected idx=%0d out=%0d at %0t",
                                 bit_index, tx_out, e / 2, e % 2, $time);
                    end
                end
            end else if (busy === 1'b1) begin
                n_chk++;
                if (tx_out !== p_out) begin
                    n_fail++;
                    $display("FAIL bit_hold: got %b expected %b at %0t", tx_out, p_out, $time);
                end
            end
            if (busy === 1'b1 && int'(bit_index) > max_idx) max_idx = int'(bit_index);
            if (frame_done === 1'b1) done_cnt++;
            if (busy === 1'b0) gap++;
            else begin
                if (p_busy !== 1'b1) last_gap = gap;
                gap = 0;
            end
        end
        p_busy = busy;
        p_idx  = bit_index;
        p_out  = tx_out;
    end

    // ---------------- stimulus tasks ----------------
    task automatic send(input logic [MAXB-1:0] d, input logic [3:0] nb,
                        input logic [1:0] par, input logic s2);
        int a0;
        int k;
        a0 = acc_cnt;
        k  = 0;
        @(negedge clk);
        tx_data = d; cfg_data_bits = nb; cfg_parity = par; cfg_stop2 = s2;
        tx_valid = 1'b1;
        while (acc_cnt == a0 && k < 2000) begin
            @(posedge clk); #1; k++;
        end
        n_chk++;
        if (acc_cnt == a0) begin
            n_fail++;
            $display("FAIL accept_timeout: got %0d accepts expected %0d", acc_cnt - a0, 1);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (frame_done !== 1'b1 && k < 1000) begin
            @(negedge clk); k++;
        end
        n_chk++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: got frame_done=%b expected 1", nm, frame_done);
        end
        @(negedge clk);
        n_chk++;
        if (bitq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_bits_left: got %0d unsent bits expected 0", nm, bitq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (tx_out !== 1'b1) begin n_fail++; $display("FAIL rst_tx_out: got %b expected 1", tx_out); end
        n_chk++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: got %b expected 1", tx_ready); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_chk++;
        if (bit_index !== '0) begin n_fail++; $display("FAIL rst_bit_index: got %0d expected 0", bit_index); end
        n_chk++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_8n1();
        int d0;
        d0 = done_cnt; max_idx = 0;
        send(9'h055, 4'd8, 2'b00, 1'b0);
        wait_done("8n1");
        n_chk++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL 8n1_done_count: got %0d expected 1", done_cnt - d0); end
        n_chk++;
        if (max_idx != 9) begin n_fail++; $display("FAIL 8n1_max_idx: got %0d expected 9", max_idx); end
        n_chk++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL 8n1_ready: got %b expected 1", tx_ready); end
    endtask

    task automatic test_even_parity();
        max_idx = 0;
        send(9'h00F, 4'd8, 2'b01, 1'b1);
        wait_done("even");
        n_chk++;
        if (max_idx != 11) begin n_fail++; $display("FAIL even_max_idx: got %0d expected 11", max_idx); end
    endtask

    task automatic test_odd_mark();
        send(9'h00F, 4'd8, 2'b10, 1'b0);
        wait_done("odd");
        max_idx = 0;
        send(9'h193, 4'd7, 2'b11, 1'b0);   // bits 8:7 set but outside a 7-bit frame
        wait_done("mark");
        n_chk++;
        if (max_idx != 9) begin n_fail++; $display("FAIL mark_max_idx: got %0d expected 9", max_idx); end
    endtask

    task automatic test_clamp();
        max_idx = 0;
        send(9'h1E5, 4'd2, 2'b00, 1'b0);
        wait_done("clamp_lo");
        n_chk++;
        if (max_idx != 6) begin n_fail++; $display("FAIL clamp_lo_max_idx: got %0d expected 6", max_idx); end
        max_idx = 0;
        send(9'h1A5, 4'd15, 2'b01, 1'b1);
        wait_done("clamp_hi");
        n_chk++;
        if (max_idx != 12) begin n_fail++; $display("FAIL clamp_hi_max_idx: got %0d expected 12", max_idx); end
    endtask

    task automatic test_back_to_back();
        int a0;
        int d0;
        int k;
        a0 = acc_cnt; d0 = done_cnt; k = 0;
        @(negedge clk);
        tx_data = 9'h0A3; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        tx_valid = 1'b1;
        while (acc_cnt == a0 && k < 2000) begin @(posedge clk); #1; k++; end
        @(negedge clk);
        // New config and data arrive mid-frame while valid stays high
        tx_data = 9'h13C; cfg_data_bits = 4'd9; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
        k = 0;
        while (acc_cnt < a0 + 2 && k < 2000) begin @(posedge clk); #1; k++; end
        n_chk++;
        if (acc_cnt != a0 + 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", acc_cnt - a0); end
        @(negedge clk);
        tx_valid = 1'b0;
        n_chk++;
        if (last_gap != 1) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d expected 1", last_gap); end
        max_idx = 0;
        wait_done("b2b");
        n_chk++;
        if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
        n_chk++;
        if (max_idx != 12) begin n_fail++; $display("FAIL b2b_max_idx: got %0d expected 12", max_idx); end
    endtask

    task automatic test_reset_midframe();
        int d0;
        int k;
        k = 0;
        send(9'h055, 4'd8, 2'b00, 1'b0);
        while (bit_index !== 4'd4 && k < 1000) begin @(negedge clk); k++; end
        n_chk++;
        if (bit_index !== 4'd4) begin n_fail++; $display("FAIL midrst_reach: got idx=%0d expected 4", bit_index); end
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (tx_out !== 1'b1) begin n_fail++; $display("FAIL midrst_tx_out: got %b expected 1", tx_out); end
        n_chk++;
        if (bit_index !== '0) begin n_fail++; $display("FAIL midrst_bit_index: got %0d expected 0", bit_index); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_chk++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", tx_ready); end
        n_chk++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", frame_done); end
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        n_chk++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_even_parity();
        test_odd_mark();
        test_clamp();
        test_back_to_back();
        test_reset_midframe();
        n_chk++;
        if (bitq.size() != 0) begin n_fail++; $display("FAIL final_queue: got %0d expected 0", bitq.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
